// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and the
// memory-wait FSM state type.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand EX forwarding select: youngest producer (MEM) wins over WB, x0 is never
// forwarded.
module fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        sel
);

  logic mem_hit_s;
  logic wb_hit_s;

  assign mem_hit_s = mem_regwrite & (mem_rd != {REG_AW{1'b0}}) & (mem_rd == src_rs);
  assign wb_hit_s  = wb_regwrite  & (wb_rd  != {REG_AW{1'b0}}) & (wb_rd  == src_rs);

  // Priority select of the operand source
  always_comb begin
    sel = FWD_RF;
    if (mem_hit_s) begin
      sel = FWD_MEM;
    end else if (wb_hit_s) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: forwarding, load-use bubble, redirect
// flush and memory-wait freeze with timeout. Optional perf counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15,
`ifdef HAZARD_PERF_EN
  parameter int PERF_W      = 32,
`endif
  parameter int TO_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_redirect,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic              mem_req,
  input  logic              mio_ready,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush,
  output logic [PERF_W-1:0] perf_freeze,
`endif
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              id_ex_we,
  output logic              ex_mem_we,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              mem_wb_bubble,
  output logic              mem_abort
);

  localparam logic            TO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

  hz_state_t       state_r, state_s;
  logic [TO_W-1:0] cnt_r, cnt_s;
  logic            freeze_s;
  logic            load_use_s;
  logic [1:0]      fwd_a_s, fwd_b_s;

  // An aborted access is released for its retiring cycle even though the bus is still busy
  assign freeze_s   = mem_req & ~mio_ready & (state_r != ABORT);
  assign load_use_s = ex_memread & (ex_rd != {REG_AW{1'b0}}) &
                      ((id_use1 & (ex_rd == id_rs1)) | (id_use2 & (ex_rd == id_rs2)));

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src_rs(ex_rs1), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(fwd_a_s)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src_rs(ex_rs2), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(fwd_b_s)
  );

  // Memory-wait state and timeout counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
      cnt_r   <= {TO_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Memory-wait next state; counter saturates so a zero timeout can wait indefinitely
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      RUN: begin
        if (freeze_s) begin
          state_s = WAIT;
          cnt_s   = TO_W'(1);
        end else begin
          state_s = RUN;
          cnt_s   = {TO_W{1'b0}};
        end
      end
      WAIT: begin
        if (mio_ready) begin
          state_s = RUN;
          cnt_s   = {TO_W{1'b0}};
        end else if (TO_EN && (cnt_r == TO_LIM)) begin
          state_s = ABORT;
          cnt_s   = {TO_W{1'b0}};
        end else if (cnt_r != {TO_W{1'b1}}) begin
          cnt_s   = cnt_r + TO_W'(1);
        end else begin
          cnt_s   = cnt_r;
        end
      end
      ABORT: begin
        state_s = RUN;
        cnt_s   = {TO_W{1'b0}};
      end
      default: begin
        state_s = RUN;
        cnt_s   = {TO_W{1'b0}};
      end
    endcase
  end

  // Stage control by priority: reset > freeze > redirect > load-use > normal
  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    ex_mem_we     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (freeze_s) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (load_use_s) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_flush   = 1'b1;
    end else begin
      mem_wb_bubble = 1'b0;
    end
  end

  assign fwd_a     = rst ? fwd_a_s : FWD_RF;
  assign fwd_b     = rst ? fwd_b_s : FWD_RF;
  assign mem_abort = rst & (state_r == ABORT);

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_r, perf_flush_r, perf_freeze_r;

  // Event counters count the condition that actually won the priority this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_r  <= {PERF_W{1'b0}};
      perf_flush_r  <= {PERF_W{1'b0}};
      perf_freeze_r <= {PERF_W{1'b0}};
    end else begin
      if (freeze_s) begin
        perf_freeze_r <= perf_freeze_r + PERF_W'(1);
      end else if (ex_redirect) begin
        perf_flush_r  <= perf_flush_r + PERF_W'(1);
      end else if (load_use_s) begin
        perf_stall_r  <= perf_stall_r + PERF_W'(1);
      end else begin
        perf_stall_r  <= perf_stall_r;
      end
    end
  end

  assign perf_stall  = perf_stall_r;
  assign perf_flush  = perf_flush_r;
  assign perf_freeze = perf_freeze_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl: two instances (timeout 4 and
// timeout 0) checked every cycle against a behavioural model, plus directed scenarios.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use1, id_use2, ex_memread, ex_redirect, mem_regwrite, wb_regwrite, mem_req, mio_ready;

  logic [1:0] fwd_a [2];
  logic [1:0] fwd_b [2];
  logic pc_we [2], if_id_we [2], id_ex_we [2], ex_mem_we [2];
  logic if_id_flush [2], id_ex_flush [2], mem_wb_bubble [2], mem_abort [2];
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall [2], perf_flush [2], perf_freeze [2];
  logic [31:0] m_ps [2], m_pf [2], m_pz [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // model state per instance: waiting flag, wait counter, abort-cycle flag
  int m_wait [2];
  int m_cnt  [2];
  int m_abort[2];
  int tov    [2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(4), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mem_req(mem_req), .mio_ready(mio_ready),
`ifdef HAZARD_PERF_EN
    .perf_stall(perf_stall[0]), .perf_flush(perf_flush[0]), .perf_freeze(perf_freeze[0]),
`endif
    .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .pc_we(pc_we[0]), .if_id_we(if_id_we[0]),
    .id_ex_we(id_ex_we[0]), .ex_mem_we(ex_mem_we[0]), .if_id_flush(if_id_flush[0]),
    .id_ex_flush(id_ex_flush[0]), .mem_wb_bubble(mem_wb_bubble[0]), .mem_abort(mem_abort[0])
  );

  pipe_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(0), .TO_W(4)) dut0 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mem_req(mem_req), .mio_ready(mio_ready),
`ifdef HAZARD_PERF_EN
    .perf_stall(perf_stall[1]), .perf_flush(perf_flush[1]), .perf_freeze(perf_freeze[1]),
`endif
    .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .pc_we(pc_we[1]), .if_id_we(if_id_we[1]),
    .id_ex_we(id_ex_we[1]), .ex_mem_we(ex_mem_we[1]), .if_id_flush(if_id_flush[1]),
    .id_ex_flush(id_ex_flush[1]), .mem_wb_bubble(mem_wb_bubble[1]), .mem_abort(mem_abort[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_bubble, mem_abort}
  function automatic logic [7:0] ctl_of(input int k);
    return {pc_we[k], if_id_we[k], id_ex_we[k], ex_mem_we[k],
            if_id_flush[k], id_ex_flush[k], mem_wb_bubble[k], mem_abort[k]};
  endfunction

  function automatic logic [1:0] fwd_exp(input logic [AW-1:0] rs);
    if (!rst) return 2'b00;
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit hold_now(input int k);
    return mem_req && !mio_ready && (m_abort[k] == 0);
  endfunction

  function automatic bit lu_now();
    return ex_memread && ex_rd != 0 &&
           ((id_use1 && ex_rd == id_rs1) || (id_use2 && ex_rd == id_rs2));
  endfunction

  function automatic logic [7:0] ctl_exp(input int k);
    logic ab;
    ab = (m_abort[k] != 0);
    if (!rst)          return 8'b0000_1110;
    if (hold_now(k))   return 8'b0000_0010;
    if (ex_redirect)   return {7'b1111_110, ab};
    if (lu_now())      return {7'b0011_010, ab};
    return {7'b1111_000, ab};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_cnt[k] = 0; m_abort[k] = 0;
`ifdef HAZARD_PERF_EN
      m_ps[k] = 32'd0; m_pf[k] = 32'd0; m_pz[k] = 32'd0;
`endif
    end
  endtask

  task automatic model_advance();
    if (!rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
`ifdef HAZARD_PERF_EN
      if (hold_now(k))      m_pz[k] = m_pz[k] + 32'd1;
      else if (ex_redirect) m_pf[k] = m_pf[k] + 32'd1;
      else if (lu_now())    m_ps[k] = m_ps[k] + 32'd1;
`endif
      if (m_abort[k] != 0) begin
        m_abort[k] = 0;
      end else if (m_wait[k] != 0) begin
        if (mio_ready) begin
          m_wait[k] = 0;
        end else if (tov[k] != 0 && m_cnt[k] == tov[k]) begin
          m_wait[k] = 0;
          m_abort[k] = 1;
        end else if (m_cnt[k] < 15) begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end else if (hold_now(k)) begin
        m_wait[k] = 1;
        m_cnt[k] = 1;
      end
    end
  endtask

  // compare both instances against the model, then cross one rising edge
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("ctl%0d", k), {24'd0, ctl_of(k)}, {24'd0, ctl_exp(k)});
      check_val($sformatf("fwd%0d", k), {28'd0, fwd_a[k], fwd_b[k]},
                {28'd0, fwd_exp(ex_rs1), fwd_exp(ex_rs2)});
`ifdef HAZARD_PERF_EN
      check_val($sformatf("pstall%0d", k), perf_stall[k], m_ps[k]);
      check_val($sformatf("pflush%0d", k), perf_flush[k], m_pf[k]);
      check_val($sformatf("pfreeze%0d", k), perf_freeze[k], m_pz[k]);
`endif
    end
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    id_use1 = 1'b0; id_use2 = 1'b0; ex_memread = 1'b0; ex_redirect = 1'b0;
    mem_regwrite = 1'b0; wb_regwrite = 1'b0; mem_req = 1'b0; mio_ready = 1'b0;
  endtask

  task automatic load_use_setup();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use1 = 1'b1; id_rs2 = 5'd1; id_use2 = 1'b1;
  endtask

  initial begin
    tov[0] = 4; tov[1] = 0;
    idle();
    model_reset();
    #2;
    check_val("rst_ctl", {24'd0, ctl_of(0)}, 32'h0E);
    check_val("rst_abort", {31'd0, mem_abort[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // load-use bubble, then the load forwards from WB
    idle(); load_use_setup();
    #1 check_val("t1_bubble", {24'd0, ctl_of(0)}, 32'h34);
    step();
    idle(); mem_rd = 5'd5; mem_regwrite = 1'b1;
    step();
    idle(); wb_rd = 5'd5; wb_regwrite = 1'b1; ex_rs1 = 5'd5; ex_rs2 = 5'd1;
    #1 check_val("t1_fwd_a", {30'd0, fwd_a[0]}, 32'd1);
    step();

    // MEM beats WB; x0 never forwarded; WB alone forwards
    idle(); mem_rd = 5'd3; mem_regwrite = 1'b1; wb_rd = 5'd3; wb_regwrite = 1'b1; ex_rs2 = 5'd3;
    #1 check_val("t2_fwd_b", {30'd0, fwd_b[0]}, 32'd2);
    step();
    idle(); mem_regwrite = 1'b1; wb_rd = 5'd3; wb_regwrite = 1'b1; ex_rs2 = 5'd3;
    #1 check_val("t2_fwd_a_x0", {30'd0, fwd_a[0]}, 32'd0);
    check_val("t2_fwd_b_wb", {30'd0, fwd_b[0]}, 32'd1);
    step();

    // redirect supersedes load-use
    idle(); load_use_setup(); ex_redirect = 1'b1;
    #1 check_val("t3_redirect", {24'd0, ctl_of(0)}, 32'hFC);
    step();

    // three wait cycles then ready
    idle(); mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_val("t4_freeze", {24'd0, ctl_of(0)}, 32'h02);
      step();
    end
    mio_ready = 1'b1;
    #1 check_val("t4_release", {24'd0, ctl_of(0)}, 32'hF0);
    step();

    // timeout: instance with limit 4 aborts, limit 0 keeps waiting
    idle(); mem_req = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #1 check_val("t5_abort", {24'd0, ctl_of(0)}, 32'hF1);
    check_val("t5_nolimit", {24'd0, ctl_of(1)}, 32'h02);
    step();
    mio_ready = 1'b1;
    step();
    idle();
    step();

    // reset in the middle of a wait
    idle(); mem_req = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    model_reset();
    #1 check_val("t6_rst", {24'd0, ctl_of(0)}, 32'h0E);
`ifdef HAZARD_PERF_EN
    check_val("t6_perf", perf_freeze[0], 32'd0);
`endif
    step();
    rst = 1'b1;
    for (int i = 0; i < 7; i++) step();
    idle(); mio_ready = 1'b1;
    step();

    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
      ex_rs1 = AW'($urandom_range(0, 3)); ex_rs2 = AW'($urandom_range(0, 3));
      ex_rd  = AW'($urandom_range(0, 3)); mem_rd = AW'($urandom_range(0, 3));
      wb_rd  = AW'($urandom_range(0, 3));
      id_use1 = 1'($urandom); id_use2 = 1'($urandom);
      ex_memread = 1'($urandom); ex_redirect = ($urandom_range(0, 3) == 0);
      mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
      mem_req = 1'($urandom); mio_ready = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
